// File: rtl/decode_result_arbiter_pkg.sv
// Shared decode definitions: payload geometry, field offsets and decoder port indices.
// Also holds the pointer-wrap helper used by the result arbiter.
package decode_result_arbiter_pkg;

   localparam int DecodePayloadWidth = 256;
   localparam int DecodeNumPorts     = 4;

   // LSB offsets of the packed decoded-instruction fields
   localparam int OpcodeLsb      = 0;
   localparam int OpcodeWidth    = 16;
   localparam int AddressLsb     = 16;
   localparam int AddressWidth   = 64;
   localparam int FuncUnitLsb    = 80;
   localparam int FuncUnitWidth  = 4;
   localparam int MajIdLsb       = 84;
   localparam int MajIdWidth     = 8;
   localparam int MinIdLsb       = 92;
   localparam int MinIdWidth     = 8;
   localparam int NumMicroOpsLsb = 100;
   localparam int Is64BitLsb     = 104;
   localparam int PidLsb         = 105;
   localparam int TidLsb         = 113;
   localparam int RwFlagsLsb     = 121;
   localparam int RegFlagsLsb    = 125;
   localparam int ImmFlagsLsb    = 133;
   localparam int BodyLsb        = 141;

   typedef enum logic [1:0] {
      PortD  = 2'd0,
      PortDs = 2'd1,
      PortX  = 2'd2,
      PortXo = 2'd3
   } decodePort_e;

   function automatic int wrapInc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/decode_result_arbiter_if.sv
// Bundle of the per-decoder result ports and the merged downstream stream.
// master = decoders plus downstream stage, slave = the arbiter.
interface decode_result_arbiter_if
   import decode_result_arbiter_pkg::*;
#(
   parameter int NumPorts     = DecodeNumPorts,
   parameter int PortIdWidth  = $clog2(NumPorts),
   parameter int PayloadWidth = DecodePayloadWidth
);
   logic [NumPorts-1:0]              enable_i;
   logic [NumPorts*PayloadWidth-1:0] payload_i;
   logic [NumPorts-1:0]              stall_o;
   logic                             stall_i;
   logic                             enable_o;
   logic [PayloadWidth-1:0]          payload_o;
   logic [PortIdWidth-1:0]           port_o;
   logic                             overflow_o;

   modport master (
      output enable_i, payload_i, stall_i,
      input  stall_o, enable_o, payload_o, port_o, overflow_o
   );

   modport slave (
      input  enable_i, payload_i, stall_i,
      output stall_o, enable_o, payload_o, port_o, overflow_o
   );
endinterface

// File: rtl/decode_result_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Emits a one-hot grant, its encoded index and whether anything was granted.
module rr_arbiter
   import decode_result_arbiter_pkg::*;
#(
   parameter int NumPorts    = DecodeNumPorts,
   parameter int PortIdWidth = $clog2(NumPorts)
) (
   input  logic [NumPorts-1:0]    req,
   input  logic [PortIdWidth-1:0] ptr,
   output logic [NumPorts-1:0]    grant,
   output logic [PortIdWidth-1:0] index,
   output logic                   anyGrant
);

   always_comb begin
      int p;
      grant    = '0;
      index    = '0;
      anyGrant = 1'b0;
      p        = 0;
      // Scan from the farthest offset down so the nearest requester wins last
      for (int i = NumPorts - 1; i >= 0; i--) begin
         p = (int'(ptr) + i) % NumPorts;
         if (req[p]) begin
            grant    = '0;
            grant[p] = 1'b1;
            index    = PortIdWidth'(p);
            anyGrant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decode_result_arbiter.sv
// Merges format-decoder result streams through 1-entry holding registers
// and a registered round-robin output stage with per-port backpressure.
module decode_result_arbiter
   import decode_result_arbiter_pkg::*;
#(
   parameter int NumPorts     = DecodeNumPorts,
   parameter int PortIdWidth  = $clog2(NumPorts),
   parameter int PayloadWidth = DecodePayloadWidth
) (
   input logic clock_i,
   input logic reset_i,
   decode_result_arbiter_if.slave bus
);

   logic [NumPorts-1:0]     holdValid;
   logic [PayloadWidth-1:0] holdPayload [NumPorts];
   logic [PortIdWidth-1:0]  rrPtr;
   logic [NumPorts-1:0]     arbGrant;
   logic [NumPorts-1:0]     grantVec;
   logic [PortIdWidth-1:0]  grantIdx;
   logic                    arbValid;
   logic                    grantEn;
   logic                    enableReg;
   logic [PayloadWidth-1:0] payloadReg;
   logic [PortIdWidth-1:0]  portReg;
   logic                    overflowReg;

   rr_arbiter #(
      .NumPorts    (NumPorts),
      .PortIdWidth (PortIdWidth)
   ) uArb (
      .req      (holdValid),
      .ptr      (rrPtr),
      .grant    (arbGrant),
      .index    (grantIdx),
      .anyGrant (arbValid)
   );

   assign grantEn     = arbValid & ~bus.stall_i;
   assign grantVec    = grantEn ? arbGrant : '0;
   assign bus.stall_o = holdValid & ~grantVec;

   // Hold stage: drain on grant, fill on enable; a full ungranted port keeps its beat
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         holdValid   <= '0;
         overflowReg <= 1'b0;
      end else begin
         holdValid   <= (holdValid & ~grantVec) | bus.enable_i;
         overflowReg <= overflowReg | (|(bus.enable_i & holdValid & ~grantVec));
      end
   end

   always_ff @(posedge clock_i) begin
      for (int p = 0; p < NumPorts; p++) begin
         if (bus.enable_i[p] && (grantVec[p] || !holdValid[p])) begin
            holdPayload[p] <= bus.payload_i[p*PayloadWidth +: PayloadWidth];
         end
      end
   end

   // Output stage: everything, including the pointer, freezes while downstream stalls
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         enableReg  <= 1'b0;
         payloadReg <= '0;
         portReg    <= '0;
         rrPtr      <= '0;
      end else if (grantEn) begin
         enableReg  <= 1'b1;
         payloadReg <= holdPayload[grantIdx];
         portReg    <= grantIdx;
         rrPtr      <= PortIdWidth'(wrapInc(int'(grantIdx), NumPorts));
      end else if (!bus.stall_i) begin
         enableReg  <= 1'b0;
      end
   end

   assign bus.enable_o   = enableReg;
   assign bus.payload_o  = payloadReg;
   assign bus.port_o     = portReg;
   assign bus.overflow_o = overflowReg;

endmodule

// File: tb/tb_decode_result_arbiter.sv
// Directed bench for decode_result_arbiter: vector table for burst/streaming
// traffic, hand-written sequences for stall, overflow and async reset.
module tb_decode_result_arbiter;
   import decode_result_arbiter_pkg::*;

   localparam int Np = 4;
   localparam int Pw = 256;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   decode_result_arbiter_if #(.NumPorts(Np), .PortIdWidth(2), .PayloadWidth(Pw)) bus ();

   decode_result_arbiter #(
      .NumPorts     (Np),
      .PortIdWidth  (2),
      .PayloadWidth (Pw)
   ) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] en;
      logic       stall;
      logic [7:0] base;
      logic       eEn;
      logic [1:0] ePort;
      logic [7:0] eByte;
      logic [3:0] eStall;
      logic       eOvf;
   } vec_t;

   vec_t vecs [18];

   function automatic logic [Pw-1:0] pat(input logic [7:0] b);
      return {32{b}};
   endfunction

   function automatic vec_t mkv(input logic [3:0] en, input logic stall, input logic [7:0] base,
                                input logic eEn, input logic [1:0] ePort, input logic [7:0] eByte,
                                input logic [3:0] eStall, input logic eOvf);
      vec_t v;
      v.en = en; v.stall = stall; v.base = base;
      v.eEn = eEn; v.ePort = ePort; v.eByte = eByte; v.eStall = eStall; v.eOvf = eOvf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [Pw-1:0] act, input logic [Pw-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Port p carries the byte pattern base+p
   task automatic drive(input logic [3:0] en, input logic stall, input logic [7:0] base);
      bus.enable_i = en;
      bus.stall_i  = stall;
      for (int p = 0; p < Np; p++) bus.payload_i[p*Pw +: Pw] = pat(8'(base + 8'(p)));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chkOut(input string tag, input logic eEn, input logic [1:0] ePort, input logic [7:0] eByte);
      chk({tag, " enable_o"}, Pw'(bus.enable_o), Pw'(eEn));
      if (eEn) begin
         chk({tag, " port_o"}, Pw'(bus.port_o), Pw'(ePort));
         chk({tag, " payload_o"}, bus.payload_o, pat(eByte));
      end
   endtask

   task automatic doReset();
      drive(4'b0000, 1'b0, 8'h00);
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      drive(4'b0000, 1'b0, 8'h00);

      vecs[0] = mkv(4'b1111, 1'b0, 8'h10, 1'b0, 2'd0, 8'h00, 4'b1110, 1'b0);
      vecs[1] = mkv(4'b0000, 1'b0, 8'h00, 1'b1, 2'd0, 8'h10, 4'b1100, 1'b0);
      vecs[2] = mkv(4'b0000, 1'b0, 8'h00, 1'b1, 2'd1, 8'h11, 4'b1000, 1'b0);
      vecs[3] = mkv(4'b0000, 1'b0, 8'h00, 1'b1, 2'd2, 8'h12, 4'b0000, 1'b0);
      vecs[4] = mkv(4'b0000, 1'b0, 8'h00, 1'b1, 2'd3, 8'h13, 4'b0000, 1'b0);
      vecs[5] = mkv(4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
      vecs[6] = mkv(4'b0100, 1'b0, 8'h20, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
      for (int i = 1; i < 10; i++)
         vecs[6+i] = mkv(4'b0100, 1'b0, 8'(8'h20 + i), 1'b1, 2'd2, 8'(8'h21 + i), 4'b0000, 1'b0);
      vecs[16] = mkv(4'b0000, 1'b0, 8'h00, 1'b1, 2'd2, 8'h2B, 4'b0000, 1'b0);
      vecs[17] = mkv(4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);

      #11;
      chk("reset enable_o", Pw'(bus.enable_o), '0);
      chk("reset payload_o", bus.payload_o, '0);
      chk("reset port_o", Pw'(bus.port_o), '0);
      chk("reset overflow_o", Pw'(bus.overflow_o), '0);
      chk("reset stall_o", Pw'(bus.stall_o), '0);
      rst = 1'b0;

      // Single beat on port 0: output on the second edge, gone on the third
      drive(4'b0001, 1'b0, 8'hA5);
      tick();
      chkOut("single e1", 1'b0, 2'd0, 8'h00);
      chk("single e1 stall_o", Pw'(bus.stall_o), '0);
      drive(4'b0000, 1'b0, 8'h00);
      tick();
      chkOut("single e2", 1'b1, 2'd0, 8'hA5);
      tick();
      chkOut("single e3", 1'b0, 2'd0, 8'h00);
      chk("single overflow_o", Pw'(bus.overflow_o), '0);

      doReset();
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].en, vecs[i].stall, vecs[i].base);
         tick();
         chkOut($sformatf("vec%0d", i), vecs[i].eEn, vecs[i].ePort, vecs[i].eByte);
         chk($sformatf("vec%0d stall_o", i), Pw'(bus.stall_o), Pw'(vecs[i].eStall));
         chk($sformatf("vec%0d overflow_o", i), Pw'(bus.overflow_o), Pw'(vecs[i].eOvf));
      end

      // Downstream stall with ports 1 and 3 loaded behind an emitted port-0 beat
      doReset();
      drive(4'b0001, 1'b0, 8'h30);
      tick();
      drive(4'b1010, 1'b0, 8'h30);
      tick();
      chkOut("stall pre", 1'b1, 2'd0, 8'h30);
      drive(4'b0000, 1'b1, 8'h00);
      #1;
      chk("stall stall_o", Pw'(bus.stall_o), Pw'(4'b1010));
      for (int i = 0; i < 5; i++) begin
         tick();
         chkOut($sformatf("stall c%0d", i), 1'b1, 2'd0, 8'h30);
         chk($sformatf("stall c%0d stall_o", i), Pw'(bus.stall_o), Pw'(4'b1010));
      end
      drive(4'b0000, 1'b0, 8'h00);
      tick();
      chkOut("release 1", 1'b1, 2'd1, 8'h31);
      tick();
      chkOut("release 2", 1'b1, 2'd3, 8'h33);
      tick();
      chkOut("release 3", 1'b0, 2'd0, 8'h00);

      // Overflow: second beat into a full, stalled port 0 is dropped
      drive(4'b0001, 1'b1, 8'h40);
      tick();
      chk("ovf before", Pw'(bus.overflow_o), '0);
      chk("ovf stall_o", Pw'(bus.stall_o), Pw'(4'b0001));
      drive(4'b0001, 1'b1, 8'h41);
      tick();
      chk("ovf set", Pw'(bus.overflow_o), Pw'(1'b1));
      drive(4'b0000, 1'b1, 8'h00);
      tick();
      chk("ovf sticky", Pw'(bus.overflow_o), Pw'(1'b1));
      drive(4'b0000, 1'b0, 8'h00);
      tick();
      chkOut("ovf emit", 1'b1, 2'd0, 8'h40);
      tick();
      chkOut("ovf after", 1'b0, 2'd0, 8'h00);
      chk("ovf still", Pw'(bus.overflow_o), Pw'(1'b1));

      // Async reset mid-cycle with three ports held and a live output beat
      drive(4'b0111, 1'b0, 8'h50);
      tick();
      drive(4'b0000, 1'b0, 8'h00);
      tick();
      chkOut("areset pre", 1'b1, 2'd1, 8'h51);
      #2;
      rst = 1'b1;
      #1;
      chk("areset enable_o", Pw'(bus.enable_o), '0);
      chk("areset payload_o", bus.payload_o, '0);
      chk("areset port_o", Pw'(bus.port_o), '0);
      chk("areset overflow_o", Pw'(bus.overflow_o), '0);
      chk("areset stall_o", Pw'(bus.stall_o), '0);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chkOut($sformatf("post reset c%0d", i), 1'b0, 2'd0, 8'h00);
         chk($sformatf("post reset c%0d stall_o", i), Pw'(bus.stall_o), '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
